operation_mux: RTL and testbench

Result-select stage of the CPU datapath. It takes the nine 16-bit results computed in parallel by the ALU functional units and selects one of them by the 4-bit instruction opcode. The selected value, plus status flags, is registered for the writeback/flag logic. It sits between the ALU units and the register-file write port.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/op_decode.sv | 28 ++
 rtl/operation_mux.sv | 78 +++++++
 tb/tb_operation_mux.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result-select stage: widths, opcode map and
// the one-hot select layout used between the decoder and the output mux.
package alu_pkg;

  localparam int DATA_W  = 16;
  localparam int OP_W    = 4;
  localparam int NUM_OPS = 9;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0010;
  localparam logic [OP_W-1:0] OP_MULT = 4'b0011;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0100;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0101;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0110;
  localparam logic [OP_W-1:0] OP_RS   = 4'b0111;
  localparam logic [OP_W-1:0] OP_LS   = 4'b1000;
  localparam logic [OP_W-1:0] OP_RR   = 4'b1001;

  // Bit positions inside the one-hot select vector
  typedef enum int unsigned {
    SEL_ADD  = 0,
    SEL_SUB  = 1,
    SEL_MULT = 2,
    SEL_OR   = 3,
    SEL_AND  = 4,
    SEL_XOR  = 5,
    SEL_RS   = 6,
    SEL_LS   = 7,
    SEL_RR   = 8
  } sel_idx_e;

  typedef logic [NUM_OPS-1:0] sel_t;
  typedef logic [DATA_W-1:0]  data_t;

  typedef struct packed {
    data_t result;
    logic  zero;
    logic  negative;
    logic  illegal_op;
  } status_t;

  function automatic status_t make_status(input data_t value, input logic illegal);
    status_t s;
    s.result     = value;
    s.zero       = (value == '0);
    s.negative   = value[DATA_W-1];
    s.illegal_op = illegal;
    return s;
  endfunction

endpackage

// File: rtl/op_decode.sv
// Combinational opcode decoder: produces a one-hot unit select plus an
// illegal flag for every opcode outside the map (select is then all zero).
module op_decode
  import alu_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output sel_t            sel,
  output logic            illegal
);

  always_comb begin
    sel     = '0;
    illegal = 1'b0;
    case (opcode)
      OP_ADD:  sel[SEL_ADD]  = 1'b1;
      OP_SUB:  sel[SEL_SUB]  = 1'b1;
      OP_MULT: sel[SEL_MULT] = 1'b1;
      OP_OR:   sel[SEL_OR]   = 1'b1;
      OP_AND:  sel[SEL_AND]  = 1'b1;
      OP_XOR:  sel[SEL_XOR]  = 1'b1;
      OP_RS:   sel[SEL_RS]   = 1'b1;
      OP_LS:   sel[SEL_LS]   = 1'b1;
      OP_RR:   sel[SEL_RR]   = 1'b1;
      default: illegal       = 1'b1;
    endcase
  end

endmodule

// File: rtl/operation_mux.sv
// Result-select stage: picks one of nine ALU unit results by opcode and
// registers it together with zero/negative/illegal status for writeback.
module operation_mux
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] ADD,
  input  logic [DATA_W-1:0] SUB,
  input  logic [DATA_W-1:0] MULT,
  input  logic [DATA_W-1:0] OR,
  input  logic [DATA_W-1:0] AND,
  input  logic [DATA_W-1:0] XOR,
  input  logic [DATA_W-1:0] RS,
  input  logic [DATA_W-1:0] LS,
  input  logic [DATA_W-1:0] RR,
  input  logic [OP_W-1:0]   opcode,
  output logic [DATA_W-1:0] result,
  output logic              out_valid,
  output logic              zero,
  output logic              negative,
  output logic              illegal_op
);

  sel_t    sel;
  logic    illegal;
  data_t   units [NUM_OPS];
  data_t   selected;
  status_t next_status;

  op_decode u_decode (
    .opcode  (opcode),
    .sel     (sel),
    .illegal (illegal)
  );

  always_comb begin
    units[SEL_ADD]  = ADD;
    units[SEL_SUB]  = SUB;
    units[SEL_MULT] = MULT;
    units[SEL_OR]   = OR;
    units[SEL_AND]  = AND;
    units[SEL_XOR]  = XOR;
    units[SEL_RS]   = RS;
    units[SEL_LS]   = LS;
    units[SEL_RR]   = RR;
  end

  // AND-OR mux: an all-zero select (illegal opcode) naturally yields 0
  always_comb begin
    selected = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      selected = selected | ({DATA_W{sel[i]}} & units[i]);
    end
  end

  assign next_status = make_status(selected, illegal);

  always_ff @(posedge clk) begin
    if (reset) begin
      result     <= '0;
      out_valid  <= 1'b0;
      zero       <= 1'b1;
      negative   <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result     <= next_status.result;
        zero       <= next_status.zero;
        negative   <= next_status.negative;
        illegal_op <= next_status.illegal_op;
      end
    end
  end

endmodule

// File: tb/tb_operation_mux.sv
// Self-checking bench for operation_mux: directed scenarios followed by
// randomized traffic compared against a behavioural opcode-table model.
module tb_operation_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] units [9];
  logic [3:0]  opcode;
  logic [15:0] result;
  logic        out_valid, zero, negative, illegal_op;

  logic [15:0] exp_result;
  logic        exp_valid, exp_zero, exp_negative, exp_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operation_mux dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .ADD        (units[0]),
    .SUB        (units[1]),
    .MULT       (units[2]),
    .OR         (units[3]),
    .AND        (units[4]),
    .XOR        (units[5]),
    .RS         (units[6]),
    .LS         (units[7]),
    .RR         (units[8]),
    .opcode     (opcode),
    .result     (result),
    .out_valid  (out_valid),
    .zero       (zero),
    .negative   (negative),
    .illegal_op (illegal_op)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Opcodes 1..9 name units 0..8 in table order; everything else reads as zero and illegal
  task automatic modelStep(input logic rst, input logic v, input logic [3:0] op);
    logic [15:0] picked;
    bit          legal;
    legal  = (op >= 1) && (op <= 9);
    picked = legal ? units[op - 1] : 16'h0000;
    if (rst) begin
      exp_result = 0; exp_valid = 0; exp_zero = 1; exp_negative = 0; exp_illegal = 0;
    end else begin
      exp_valid = v;
      if (v) begin
        exp_result   = picked;
        exp_zero     = (picked == 0);
        exp_negative = (picked >= 16'h8000);
        exp_illegal  = !legal;
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic v, input logic [3:0] op, input string tag);
    @(negedge clk);
    reset    = rst;
    in_valid = v;
    opcode   = op;
    @(posedge clk);
    modelStep(rst, v, op);
    #1;
    checkOutput({tag, ".result"},   result,            exp_result);
    checkOutput({tag, ".valid"},    {15'b0, out_valid},  {15'b0, exp_valid});
    checkOutput({tag, ".zero"},     {15'b0, zero},       {15'b0, exp_zero});
    checkOutput({tag, ".negative"}, {15'b0, negative},   {15'b0, exp_negative});
    checkOutput({tag, ".illegal"},  {15'b0, illegal_op}, {15'b0, exp_illegal});
  endtask

  task automatic loadPlanUnits();
    units[0] = 16'd10; units[1] = 16'd5; units[2] = 16'd52;
    units[3] = 16'd1;  units[4] = 16'd3; units[5] = 16'd2;
    units[6] = 16'd1;  units[7] = 16'd1; units[8] = 16'd234;
  endtask

  initial begin
    logic [15:0] plan_expect [9];
    logic [3:0]  illegal_ops [3];
    plan_expect = '{16'd10, 16'd5, 16'd52, 16'd1, 16'd3, 16'd2, 16'd1, 16'd1, 16'd234};
    illegal_ops = '{4'b0000, 4'b1010, 4'b1111};

    reset = 1; in_valid = 0; opcode = 0;
    loadPlanUnits();
    applyStimulus(1, 0, 0, "reset0");
    applyStimulus(1, 1, 4'd1, "reset1");

    // Full legal sweep with the reference values of the test plan
    for (int op = 1; op <= 9; op++) begin
      applyStimulus(0, 1, op[3:0], "sweep");
      checkOutput("sweep.const", result, plan_expect[op - 1]);
    end

    foreach (illegal_ops[i]) applyStimulus(0, 1, illegal_ops[i], "illegal");

    units[0] = 16'h8000;
    applyStimulus(0, 1, 4'd1, "neg");
    checkOutput("neg.const", {15'b0, negative}, 16'd1);
    units[1] = 16'h0000;
    applyStimulus(0, 1, 4'd2, "zero");
    checkOutput("zero.const", {15'b0, zero}, 16'd1);

    loadPlanUnits();
    applyStimulus(0, 1, 4'd9, "rr");
    for (int i = 0; i < 3; i++) begin
      for (int u = 0; u < 9; u++) units[u] = 16'($urandom);
      applyStimulus(0, 0, 4'($urandom), "hold");
      checkOutput("hold.const", result, 16'd234);
    end

    loadPlanUnits();
    applyStimulus(0, 1, 4'd5, "pre_rst");
    applyStimulus(1, 1, 4'd1, "mid_rst");
    checkOutput("mid_rst.const", result, 16'd0);
    applyStimulus(0, 1, 4'd3, "post_rst");
    checkOutput("post_rst.const", result, 16'd52);

    // Randomized traffic with biased data to hit zero and sign-bit corners
    for (int n = 0; n < 400; n++) begin
      for (int u = 0; u < 9; u++) begin
        case ($urandom_range(0, 5))
          0: units[u] = 16'h0000;
          1: units[u] = 16'h8000 | 16'($urandom_range(0, 3));
          default: units[u] = 16'($urandom);
        endcase
      end
      applyStimulus($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
                    4'($urandom_range(0, 15)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
